mor1kx_branch_predictor_gshare_n: RTL and testbench
===================================================

# mor1kx_branch_predictor_gshare_n

Parametrised gshare predictor with N-bit saturating counters, configurable history length and hash mode, and a sweep-initialised pattern table. Sits between decode, which predicts l.bf/l.bnf, and execute, which resolves the branch, in the cappuccino pipeline. It adds a runtime clear and saturating prediction statistics.

## Interface
- OPTION_OPERAND_WIDTH, 32: width of brn_pc_i.
- INDEX_BITS, 10: table index width; table has 2**INDEX_BITS counters.
- HIST_BITS, 10: global history length, range 1..INDEX_BITS.
- CNT_BITS, 2: counter width, range 1..4.
- PC_SHIFT, 2: lowest PC bit used in the index.
- HASH_MODE, 0: 0 = gshare (PC xor history), 1 = bimodal (PC only; history still tracked).
- STAT_BITS, 16: width of the statistics counters.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- op_bf_i  in  1  decode insn is l.bf.
- op_bnf_i  in  1  decode insn is l.bnf.
- padv_decode_i  in  1  pipeline advances.
- brn_pc_i  in  OPTION_OPERAND_WIDTH  PC of the decode branch.
- predicted_flag_o  out  1  predicted flag for the decode branch.
- prev_op_brcond_i  in  1  execute insn is a conditional branch.
- execute_op_bf_i  in  1  execute insn is l.bf.
- execute_op_bnf_i  in  1  execute insn is l.bnf.
- flag_i  in  1  resolved SR[F].
- branch_mispredict_i  in  1  execute branch was mispredicted.
- clear_i  in  1  synchronous request to re-initialise table, history and stats.
- ready_o  out  1  table valid (RUN state).
- brn_count_o  out  STAT_BITS  resolved conditional branches.
- mispredict_count_o  out  STAT_BITS  resolved mispredictions.

## Operation
- FSM states are INIT and RUN. Async reset forces INIT with sweep pointer 0, history 0, prev_idx 0, stats 0 and ready_o 0.
- INIT writes WT = 2**(CNT_BITS-1) to entry ptr and increments ptr each cycle. After entry 2**INDEX_BITS-1 is written, the FSM moves to RUN.
- The counter array has no reset; only the sweep initialises it.
- clear_i in any state causes: INIT with ptr 0, history 0, stats 0.
- Index: pc_idx = brn_pc_i[PC_SHIFT+INDEX_BITS-1:PC_SHIFT]. In mode 0, idx = pc_idx xor zero-extended history; in mode 1, idx = pc_idx.
- Prediction (combinational): taken = MSB of table[idx]. predicted_flag_o = (taken & op_bf_i) | (!taken & op_bnf_i). In INIT, taken is forced to 1.
- Capture: when (op_bf_i|op_bnf_i) & padv_decode_i, prev_idx <= idx.
- Resolve event = prev_op_brcond_i & padv_decode_i.
  - brn_taken = (execute_op_bf_i & flag_i) | (execute_op_bnf_i & !flag_i).
  - History <= {history[HIST_BITS-2:0], brn_taken}.
  - table[prev_idx]: saturating +1 if taken, saturating -1 if not taken; max 2**CNT_BITS-1, min 0.
  - brn_count_o += 1; mispredict_count_o += branch_mispredict_i. Both saturate at all-ones.
- In INIT, resolve events still shift the history but leave the table and stats unchanged.

## Timing
- Prediction has zero latency from brn_pc_i, op_bf_i and op_bnf_i.
- Table, history and stats updates take effect on the clock edge after the resolve event.
- Write and read of the same index in one cycle: the read returns the old value.
- Capture and resolve in one cycle: the index uses the pre-shift history.
- ready_o rises exactly 2**INDEX_BITS cycles after rst_n deassertion or after the clear_i cycle.
- clear_i during INIT restarts the sweep from entry 0.
- Async reset mid-sweep aborts the sweep, and the next sweep restarts from 0.
- Resolve without a prior capture uses the stale prev_idx. This is legal.

## Structure
- Shared in mor1kx-defines.v: FSM encodings INIT/RUN and the HASH_MODE values.
- Sub-module mor1kx_sat_counter_next (combinational, parameter CNT_BITS): inputs value and taken; output is the saturated next value. It is used for the table update.
- The table is a flop array. Do not infer RAM, because the read is asynchronous.

## Test plan
- Reset: INDEX_BITS=4. Release rst_n -> ready_o low for 16 cycles, then high. op_bf_i=1 during INIT -> predicted_flag_o=1. All entries read 2'b10. Stats read 0.
- Saturation: CNT_BITS=2, HASH_MODE=1, PC 0x100. Apply 3 not-taken resolves -> entry 00, and an l.bf predicts 0. Then 1 taken -> 01, still predicts 0. 1 more taken -> 10, predicts 1.
- gshare aliasing: INDEX_BITS=4, history 4'b0101, PC 0x14 -> idx 0x5^0x5=0. Update entry 0 and confirm PC 0x0 with history 0 reads the same entry.
- Simultaneous: capture, resolve(taken) and same-index read in one cycle -> old prediction, and prev_idx uses the pre-shift history. The counter increments on the next cycle.
- Stats: 70000 resolves with 5 mispredicts, STAT_BITS=16 -> brn_count_o=0xFFFF, mispredict_count_o=5. clear_i -> both 0 and ready_o low for 2**INDEX_BITS cycles.
- Reset mid-sweep: assert rst_n low at sweep entry 7 and release -> sweep restarts at 0, and ready_o rises 2**INDEX_BITS cycles later.

Source files
------------

// File: rtl/mor1kx_branch_predictor_gshare_n_pkg.sv
// Shared definitions for the gshare branch predictor: FSM encodings, hash
// mode selectors and the resolved-direction helper.
package mor1kx_branch_predictor_gshare_n_pkg;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    localparam int HASH_GSHARE  = 0;
    localparam int HASH_BIMODAL = 1;

    function automatic logic brn_resolved_taken(input logic is_bf,
                                                input logic is_bnf,
                                                input logic flag);
        return (is_bf & flag) | (is_bnf & ~flag);
    endfunction

endpackage

// File: rtl/mor1kx_branch_predictor_gshare_n_sat_counter_next.sv
// Saturating up/down step for one pattern-table counter.
module mor1kx_sat_counter_next #(
    parameter int CNT_BITS = 2
) (
    input  logic [CNT_BITS-1:0] value_i,
    input  logic                taken_i,
    output logic [CNT_BITS-1:0] next_o
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_MIN = '0;

    always_comb begin
        next_o = value_i;
        if (taken_i) begin
            if (value_i != CNT_MAX) begin
                next_o = value_i + CNT_BITS'(1);
            end
        end else if (value_i != CNT_MIN) begin
            next_o = value_i - CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/mor1kx_branch_predictor_gshare_n.sv
// Gshare/bimodal predictor with N-bit counters, a sweep-initialised flop
// table, runtime clear and saturating resolve/mispredict statistics.
module mor1kx_branch_predictor_gshare_n
    import mor1kx_branch_predictor_gshare_n_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int INDEX_BITS           = 10,
    parameter int HIST_BITS            = 10,
    parameter int CNT_BITS             = 2,
    parameter int PC_SHIFT             = 2,
    parameter int HASH_MODE            = 0,
    parameter int STAT_BITS            = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            op_bf_i,
    input  logic                            op_bnf_i,
    input  logic                            padv_decode_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i,
    output logic                            predicted_flag_o,
    input  logic                            prev_op_brcond_i,
    input  logic                            execute_op_bf_i,
    input  logic                            execute_op_bnf_i,
    input  logic                            flag_i,
    input  logic                            branch_mispredict_i,
    input  logic                            clear_i,
    output logic                            ready_o,
    output logic [STAT_BITS-1:0]            brn_count_o,
    output logic [STAT_BITS-1:0]            mispredict_count_o
);

    localparam int                    TABLE_SIZE = 2 ** INDEX_BITS;
    localparam logic [CNT_BITS-1:0]   CNT_WT     = CNT_BITS'(2 ** (CNT_BITS - 1));
    localparam logic [INDEX_BITS-1:0] PTR_LAST   = INDEX_BITS'(TABLE_SIZE - 1);
    localparam logic [STAT_BITS-1:0]  STAT_MAX   = '1;

    bp_state_t             state_q, state_d;
    logic [INDEX_BITS-1:0] ptr_q, ptr_d;
    logic [HIST_BITS-1:0]  hist_q, hist_d;
    logic [INDEX_BITS-1:0] prev_idx_q, prev_idx_d;
    logic [STAT_BITS-1:0]  brn_count_q, brn_count_d;
    logic [STAT_BITS-1:0]  mispredict_count_q, mispredict_count_d;

    logic [CNT_BITS-1:0]   table_q [TABLE_SIZE];

    logic [INDEX_BITS-1:0] pc_idx;
    logic [INDEX_BITS-1:0] hist_ext;
    logic [INDEX_BITS-1:0] idx;
    logic                  taken_pred;
    logic                  capture;
    logic                  resolve;
    logic                  brn_taken;
    logic                  tbl_we;
    logic [INDEX_BITS-1:0] tbl_waddr;
    logic [CNT_BITS-1:0]   tbl_wdata;
    logic [CNT_BITS-1:0]   cnt_next;
    logic                  unused_pc_bits;

    assign pc_idx         = brn_pc_i[PC_SHIFT +: INDEX_BITS];
    assign unused_pc_bits = ^brn_pc_i;

    always_comb begin
        hist_ext                = '0;
        hist_ext[HIST_BITS-1:0] = hist_q;
    end

    assign idx = (HASH_MODE == HASH_BIMODAL) ? pc_idx : (pc_idx ^ hist_ext);

    // The table contents are meaningless until the sweep finishes, so INIT predicts taken.
    assign taken_pred       = (state_q == BP_INIT) ? 1'b1 : table_q[idx][CNT_BITS-1];
    assign predicted_flag_o = (taken_pred & op_bf_i) | (~taken_pred & op_bnf_i);

    assign capture   = (op_bf_i | op_bnf_i) & padv_decode_i;
    assign resolve   = prev_op_brcond_i & padv_decode_i;
    assign brn_taken = brn_resolved_taken(execute_op_bf_i, execute_op_bnf_i, flag_i);

    mor1kx_sat_counter_next #(
        .CNT_BITS (CNT_BITS)
    ) u_sat_next (
        .value_i (table_q[prev_idx_q]),
        .taken_i (brn_taken),
        .next_o  (cnt_next)
    );

    always_comb begin
        state_d            = state_q;
        ptr_d              = ptr_q;
        hist_d             = hist_q;
        prev_idx_d         = prev_idx_q;
        brn_count_d        = brn_count_q;
        mispredict_count_d = mispredict_count_q;
        tbl_we             = 1'b0;
        tbl_waddr          = prev_idx_q;
        tbl_wdata          = cnt_next;

        // Capture uses idx built from the pre-shift history.
        if (capture) begin
            prev_idx_d = idx;
        end
        if (resolve) begin
            hist_d = HIST_BITS'({hist_q, brn_taken});
        end

        unique case (state_q)
            BP_INIT: begin
                tbl_we    = 1'b1;
                tbl_waddr = ptr_q;
                tbl_wdata = CNT_WT;
                ptr_d     = ptr_q + INDEX_BITS'(1);
                if (ptr_q == PTR_LAST) begin
                    state_d = BP_RUN;
                end
            end
            BP_RUN: begin
                if (resolve) begin
                    tbl_we = 1'b1;
                    if (brn_count_q != STAT_MAX) begin
                        brn_count_d = brn_count_q + STAT_BITS'(1);
                    end
                    if (branch_mispredict_i && (mispredict_count_q != STAT_MAX)) begin
                        mispredict_count_d = mispredict_count_q + STAT_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = BP_INIT;
            end
        endcase

        if (clear_i) begin
            state_d            = BP_INIT;
            ptr_d              = '0;
            hist_d             = '0;
            brn_count_d        = '0;
            mispredict_count_d = '0;
            tbl_we             = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= BP_INIT;
            ptr_q              <= '0;
            hist_q             <= '0;
            prev_idx_q         <= '0;
            brn_count_q        <= '0;
            mispredict_count_q <= '0;
        end else begin
            state_q            <= state_d;
            ptr_q              <= ptr_d;
            hist_q             <= hist_d;
            prev_idx_q         <= prev_idx_d;
            brn_count_q        <= brn_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // No reset on the array: the INIT sweep is the only initialisation.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            table_q[tbl_waddr] <= tbl_wdata;
        end
    end

    assign ready_o            = (state_q == BP_RUN);
    assign brn_count_o        = brn_count_q;
    assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_mor1kx_branch_predictor_gshare_n.sv
// Self-checking bench: a gshare and a bimodal instance share one stimulus
// stream and are compared against a table-level behavioural model.
module tb_mor1kx_branch_predictor_gshare_n;

    localparam int IB = 4;
    localparam int TS = 16;

    typedef struct {
        logic        bf;
        logic        bnf;
        logic        padv;
        logic [31:0] pc;
        logic        brcond;
        logic        exbf;
        logic        exbnf;
        logic        flag;
        logic        mispred;
        logic        clr;
        logic        want_bm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_bf = 1'b0, op_bnf = 1'b0, padv = 1'b0;
    logic [31:0] pc = '0;
    logic        brcond = 1'b0, ex_bf = 1'b0, ex_bnf = 1'b0, flag = 1'b0;
    logic        mispred = 1'b0, clear = 1'b0;
    logic        pred_gs, pred_bm, ready_gs, ready_bm;
    logic [15:0] brn_gs, mis_gs, brn_bm, mis_bm;

    always #5 clk = ~clk;

    mor1kx_branch_predictor_gshare_n #(
        .OPTION_OPERAND_WIDTH(32), .INDEX_BITS(IB), .HIST_BITS(4), .CNT_BITS(2),
        .PC_SHIFT(2), .HASH_MODE(0), .STAT_BITS(16)
    ) dut_gs (
        .clk(clk), .rst_n(rst_n), .op_bf_i(op_bf), .op_bnf_i(op_bnf),
        .padv_decode_i(padv), .brn_pc_i(pc), .predicted_flag_o(pred_gs),
        .prev_op_brcond_i(brcond), .execute_op_bf_i(ex_bf), .execute_op_bnf_i(ex_bnf),
        .flag_i(flag), .branch_mispredict_i(mispred), .clear_i(clear),
        .ready_o(ready_gs), .brn_count_o(brn_gs), .mispredict_count_o(mis_gs)
    );

    mor1kx_branch_predictor_gshare_n #(
        .OPTION_OPERAND_WIDTH(32), .INDEX_BITS(IB), .HIST_BITS(4), .CNT_BITS(2),
        .PC_SHIFT(2), .HASH_MODE(1), .STAT_BITS(16)
    ) dut_bm (
        .clk(clk), .rst_n(rst_n), .op_bf_i(op_bf), .op_bnf_i(op_bnf),
        .padv_decode_i(padv), .brn_pc_i(pc), .predicted_flag_o(pred_bm),
        .prev_op_brcond_i(brcond), .execute_op_bf_i(ex_bf), .execute_op_bnf_i(ex_bnf),
        .flag_i(flag), .branch_mispredict_i(mispred), .clear_i(clear),
        .ready_o(ready_bm), .brn_count_o(brn_bm), .mispredict_count_o(mis_bm)
    );

    int total = 0;
    int bad = 0;

    // Reference model: counters as plain integers, "sweep" as a countdown.
    int init_left;
    int hist;
    int brn_cnt;
    int mis_cnt;
    int prev_idx [2];
    int tbl [2][TS];

    function automatic int model_idx(input int mode);
        int p;
        p = int'(pc[5:2]);
        return (mode == 0) ? (p ^ hist) : p;
    endfunction

    function automatic int model_pred(input int mode);
        int taken;
        if (init_left > 0) taken = 1;
        else taken = (tbl[mode][model_idx(mode)] >= 2) ? 1 : 0;
        return ((taken == 1 && op_bf) || (taken == 0 && op_bnf)) ? 1 : 0;
    endfunction

    function automatic void model_reset();
        init_left = TS;
        hist = 0;
        brn_cnt = 0;
        mis_cnt = 0;
        prev_idx[0] = 0;
        prev_idx[1] = 0;
    endfunction

    function automatic void model_edge();
        int  new_prev [2];
        bit  res;
        bit  t;
        res = brcond && padv;
        t = (ex_bf && flag) || (ex_bnf && !flag);
        for (int m = 0; m < 2; m++)
            new_prev[m] = ((op_bf || op_bnf) && padv) ? model_idx(m) : prev_idx[m];
        if (clear) begin
            init_left = TS;
            hist = 0;
            brn_cnt = 0;
            mis_cnt = 0;
        end else begin
            if (res && init_left == 0) begin
                for (int m = 0; m < 2; m++) begin
                    if (t) tbl[m][prev_idx[m]] = (tbl[m][prev_idx[m]] < 3) ? tbl[m][prev_idx[m]] + 1 : 3;
                    else   tbl[m][prev_idx[m]] = (tbl[m][prev_idx[m]] > 0) ? tbl[m][prev_idx[m]] - 1 : 0;
                end
                if (brn_cnt < 65535) brn_cnt++;
                if (mispred && mis_cnt < 65535) mis_cnt++;
            end
            if (res) hist = ((hist << 1) | int'(t)) & (TS - 1);
            if (init_left > 0) begin
                init_left--;
                if (init_left == 0)
                    for (int m = 0; m < 2; m++)
                        for (int e = 0; e < TS; e++) tbl[m][e] = 2;
            end
        end
        prev_idx = new_prev;
    endfunction

    task automatic checkOutput(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    task automatic check_model();
        checkOutput("pred_gs", int'(pred_gs), model_pred(0));
        checkOutput("pred_bm", int'(pred_bm), model_pred(1));
        checkOutput("ready_gs", int'(ready_gs), (init_left == 0) ? 1 : 0);
        checkOutput("ready_bm", int'(ready_bm), (init_left == 0) ? 1 : 0);
        checkOutput("brn_gs", int'(brn_gs), brn_cnt);
        checkOutput("mis_gs", int'(mis_gs), mis_cnt);
        checkOutput("brn_bm", int'(brn_bm), brn_cnt);
        checkOutput("mis_bm", int'(mis_bm), mis_cnt);
    endtask

    function automatic vec_t mk(input logic bf, input logic bnf, input logic pv,
                                input logic [31:0] p, input logic bc, input logic xbf,
                                input logic xbnf, input logic fl, input logic mp,
                                input logic cl, input logic want);
        vec_t v;
        v.bf = bf; v.bnf = bnf; v.padv = pv; v.pc = p; v.brcond = bc;
        v.exbf = xbf; v.exbnf = xbnf; v.flag = fl; v.mispred = mp; v.clr = cl;
        v.want_bm = want;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        op_bf = v.bf; op_bnf = v.bnf; padv = v.padv; pc = v.pc;
        brcond = v.brcond; ex_bf = v.exbf; ex_bnf = v.exbnf; flag = v.flag;
        mispred = v.mispred; clear = v.clr;
    endtask

    task automatic step_clock();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run_cycle(input vec_t v);
        applyStimulus(v);
        #1;
        check_model();
        step_clock();
    endtask

    task automatic hand_check(input vec_t v, input string name, input int want_gs);
        applyStimulus(v);
        #1;
        checkOutput(name, int'(pred_gs), want_gs);
        check_model();
        step_clock();
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        while (!ready_gs && n < 64) begin
            #1;
            check_model();
            step_clock();
            n++;
        end
        checkOutput(name, int'(ready_gs), 1);
    endtask

    task automatic count_sweep(input string name);
        for (int k = 0; k < TS; k++) begin
            #1;
            checkOutput({name, "_low"}, int'(ready_gs), 0);
            check_model();
            step_clock();
        end
        #1;
        checkOutput({name, "_high"}, int'(ready_gs), 1);
        checkOutput({name, "_high_bm"}, int'(ready_bm), 1);
    endtask

    vec_t sat_vecs [16];
    vec_t idle;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int m = 0; m < 2; m++)
            for (int e = 0; e < TS; e++) tbl[m][e] = 0;
        model_reset();

        // Saturation sequence at PC 0x100 (bimodal entry 0): bf, bnf, resolve, exbf, exbnf, flag.
        sat_vecs[0]  = mk(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1);
        sat_vecs[1]  = mk(1, 0, 1, 32'h100, 1, 1, 0, 0, 0, 0, 1);
        sat_vecs[2]  = mk(1, 0, 1, 32'h100, 1, 1, 0, 0, 1, 0, 0);
        sat_vecs[3]  = mk(1, 0, 1, 32'h100, 1, 0, 1, 1, 0, 0, 0);
        sat_vecs[4]  = mk(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        sat_vecs[5]  = mk(1, 0, 1, 32'h100, 1, 1, 0, 1, 1, 0, 0);
        sat_vecs[6]  = mk(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        sat_vecs[7]  = mk(1, 0, 1, 32'h100, 1, 0, 1, 0, 0, 0, 0);
        sat_vecs[8]  = mk(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1);
        sat_vecs[9]  = mk(0, 1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        sat_vecs[10] = mk(1, 0, 1, 32'h100, 1, 1, 0, 1, 0, 0, 1);
        sat_vecs[11] = mk(1, 0, 1, 32'h100, 1, 1, 0, 1, 0, 0, 1);
        sat_vecs[12] = mk(1, 0, 1, 32'h100, 1, 1, 0, 0, 0, 0, 1);
        sat_vecs[13] = mk(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1);
        sat_vecs[14] = mk(1, 0, 1, 32'h100, 1, 1, 0, 0, 1, 0, 1);
        sat_vecs[15] = mk(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);

        // Reset: INIT predicts taken, stats are zero, ready after exactly 16 cycles.
        applyStimulus(mk(1, 0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("init_pred_bf", int'(pred_gs), 1);
        checkOutput("init_brn_zero", int'(brn_gs), 0);
        checkOutput("init_mis_zero", int'(mis_gs), 0);
        count_sweep("reset_ready");

        for (int e = 0; e < TS; e++) begin
            applyStimulus(mk(1, 0, 0, 32'(e << 2), 0, 0, 0, 0, 0, 0, 0));
            #1;
            checkOutput("sweep_entry_wt", int'(pred_bm), 1);
            applyStimulus(mk(0, 1, 0, 32'(e << 2), 0, 0, 0, 0, 0, 0, 0));
            #1;
            checkOutput("sweep_entry_wt_bnf", int'(pred_bm), 0);
        end

        for (int i = 0; i < 16; i++) begin
            applyStimulus(sat_vecs[i]);
            #1;
            checkOutput($sformatf("sat_vec%0d", i), int'(pred_bm), int'(sat_vecs[i].want_bm));
            check_model();
            step_clock();
        end

        // gshare aliasing: history 0101 with PC 0x14 lands on entry 0.
        run_cycle(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        wait_ready("alias_ready");
        run_cycle(mk(1, 0, 1, 32'h3C, 0, 0, 0, 0, 0, 0, 0));
        run_cycle(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        run_cycle(mk(0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0));
        run_cycle(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        run_cycle(mk(0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0));
        hand_check(mk(1, 0, 1, 32'h14, 0, 0, 0, 0, 0, 0, 0), "alias_pre", 1);
        for (int k = 0; k < 4; k++) run_cycle(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        hand_check(mk(1, 0, 1, 32'h14, 0, 0, 0, 0, 0, 0, 0), "alias_pc14_hist0", 1);
        hand_check(mk(1, 0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0), "alias_pc0_hist0", 0);

        // Same-cycle capture + resolve + read of entry 0.
        run_cycle(mk(0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 0));
        hand_check(mk(1, 0, 1, 32'h4, 1, 1, 0, 1, 0, 0, 0), "simul_old_value", 0);
        hand_check(mk(1, 0, 0, 32'hC, 0, 0, 0, 0, 0, 0, 0), "simul_next_cycle", 1);
        run_cycle(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        hand_check(mk(1, 0, 0, 32'h18, 0, 0, 0, 0, 0, 0, 0), "simul_preshift_idx", 0);

        // Statistics saturation.
        run_cycle(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        wait_ready("stats_ready");
        for (int i = 0; i < 70000; i++) begin
            applyStimulus(mk(0, 0, 1, 0, 1, 1, 0, 1'($urandom), 1'(i == 10 || i == 100 || i == 1000 || i == 30000 || i == 69999), 0, 0));
            step_clock();
        end
        applyStimulus(idle);
        #1;
        checkOutput("stats_brn_sat", int'(brn_gs), 16'hFFFF);
        checkOutput("stats_mis", int'(mis_gs), 5);
        check_model();
        step_clock();
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        step_clock();
        applyStimulus(idle);
        #1;
        checkOutput("clear_brn_zero", int'(brn_gs), 0);
        checkOutput("clear_mis_zero", int'(mis_gs), 0);
        count_sweep("clear_ready");

        // Async reset at sweep entry 7 restarts the sweep.
        run_cycle(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 7; k++) run_cycle(idle);
        rst_n = 1'b0;
        model_reset();
        #2;
        checkOutput("midreset_ready_low", int'(ready_gs), 0);
        rst_n = 1'b1;
        #1;
        count_sweep("midreset_ready");

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            v = mk(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 299) == 0), 0);
            run_cycle(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
